fpu_issue_q: RTL
================

# fpu_issue_q

Operand issue queue placed directly upstream of the combinational `fpu`. It accepts tagged floating-point requests over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It presents the head entry to the FPU operand ports and captures the FPU result into a registered, tagged output with its own valid/ready handshake. This decouples the producer from the consumer and registers the FPU's long combinational path.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- TAG_W, 4: request tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge.
- in_a, in_b  in  32  operands; for prec=0 only [15:0] is meaningful.
- in_op  in  1  0 add, 1 mul.
- in_prec  in  1  0 half, 1 single.
- in_tag  in  TAG_W  request tag, returned with the result.
- fpu_a, fpu_b  out  32  to fpu a/b.
- fpu_op, fpu_prec  out  1  to fpu op/prec.
- fpu_result  in  32  from fpu result (combinational in fpu_*).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_result  out  32  registered FPU result.
- out_tag  out  TAG_W  tag of out_result.
- q_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO storage: {a, b, op, prec, tag} per entry. Write pointer, read pointer and count are registered. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- in_ready = rst_n & (count != DEPTH). It has no combinational dependency on out_ready. A full queue refuses a request even in a cycle where it dequeues.
- Enqueue at an edge when in_valid & in_ready.
- On enqueue, prec=0 operands are stored with [31:16] forced to 0.
- fpu_* ports are driven from the head entry when count>0, otherwise from the bypass path (see Configuration), otherwise 0.
- Issue condition: slot_free = !out_valid | out_ready.
- If count>0 & slot_free at an edge:
  - the head is dequeued;
  - out_result ← fpu_result;
  - out_tag ← head tag;
  - out_valid ← 1.
- Else if out_valid & out_ready: out_valid ← 0. out_result and out_tag hold.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Results leave in strict request order.
- No flag or exception handling; fpu_result is passed unmodified.

## Timing
- Reset (async assert, sync-to-clk deassert by the system):
  - out_valid=0, out_result=0, out_tag=0;
  - count=0, pointers=0, q_count=0;
  - in_ready=0 while rst_n low.
- Reset mid-operation discards all queued entries and any pending output; no results are produced for them.
- Latency without bypass:
  - request accepted at edge N;
  - issued to the FPU during cycle N..N+1;
  - captured at edge N+1;
  - out_valid high after edge N+1, so 2 cycles.
- Throughput: 1 result/cycle while out_ready=1 and the queue is non-empty.
- Backpressure: while out_valid & !out_ready, no dequeue occurs. The queue fills, and in_ready drops after DEPTH accepted requests.
- out_result and out_tag are stable while out_valid & !out_ready.

## Configuration
- FPU_ISSUE_BYPASS_EN defined:
  - when count==0 and slot_free, fpu_* are driven combinationally from in_* (prec=0 upper halves zeroed);
  - an accepted request is captured into the output register at the same edge without entering the FIFO;
  - latency is 1 cycle;
  - a request is only bypassed if the queue is empty, so ordering is preserved.
- Undefined: every request goes through the FIFO; latency is 2 cycles; fpu_*=0 when the queue is empty.

## Test plan
The bench uses a stub FPU: fpu_result = fpu_op ? (fpu_a ^ fpu_b) : (fpu_a + fpu_b).
- Reset check: hold rst_n=0 → in_ready=0, out_valid=0, out_result=0, q_count=0. Release → in_ready=1.
- Single request, out_ready=1: {a=0x00000003, b=0x00000004, op=0, prec=1, tag=5} → out_result=0x00000007, out_tag=5. out_valid rises 2 edges later (1 edge with FPU_ISSUE_BYPASS_EN) and holds exactly one cycle.
- Half-precision upper zeroing: {a=0xFFFF0001, b=0xAAAA0002, op=1, prec=0} → out_result=0x00000003.
- Backpressure: out_ready=0, issue 6 back-to-back requests with tags 0..5:
  - q_count reaches DEPTH;
  - in_ready=0 after the 5th accept (4 queued + 1 held output);
  - then out_ready=1 → tags 0..5 emerge in order on consecutive cycles.
- Streaming: continuous in_valid=1, out_ready=1, 16 requests, tags wrapping 0..15 → 16 in-order results, one per cycle after the initial latency; pointer wrap is exercised.
- Reset mid-operation: with 3 entries queued and out_valid=1, pulse rst_n low for 1 cycle → out_valid=0 and q_count=0 immediately. None of the old tags appear afterwards.

Source files
------------

// File: rtl/fpu_issue_q.sv
// fpu_issue_q: DEPTH-entry tagged operand FIFO in front of a combinational fpu, with a
// registered, tagged result stage. Define FPU_ISSUE_BYPASS_EN for the 1-cycle empty-queue bypass.
module fpu_issue_q #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_a,
    input  logic [31:0]            in_b,
    input  logic                   in_op,
    input  logic                   in_prec,
    input  logic [TAG_W-1:0]       in_tag,
    output logic [31:0]            fpu_a,
    output logic [31:0]            fpu_b,
    output logic                   fpu_op,
    output logic                   fpu_prec,
    input  logic [31:0]            fpu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic             op;
        logic             prec;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    entry_t in_entry;
    entry_t head;
    logic   q_empty;
    logic   slot_free;
    logic   in_fire;
    logic   enq;
    logic   deq;
    logic   bypass;

    always_comb begin
        // half-precision requests carry only the low 16 bits
        in_entry.a    = in_prec ? in_a : {16'h0000, in_a[15:0]};
        in_entry.b    = in_prec ? in_b : {16'h0000, in_b[15:0]};
        in_entry.op   = in_op;
        in_entry.prec = in_prec;
        in_entry.tag  = in_tag;

        head      = mem_q[rd_ptr_q];
        q_empty   = (count_q == '0);
        slot_free = !out_valid_q || out_ready;
        in_ready  = rst_n && (count_q != FULL);
        in_fire   = in_valid && in_ready;
        deq       = !q_empty && slot_free;
`ifdef FPU_ISSUE_BYPASS_EN
        bypass    = in_fire && q_empty && slot_free;
`else
        bypass    = 1'b0;
`endif
        enq       = in_fire && !bypass;
    end

    always_comb begin
        fpu_a    = '0;
        fpu_b    = '0;
        fpu_op   = 1'b0;
        fpu_prec = 1'b0;
        if (!q_empty) begin
            fpu_a    = head.a;
            fpu_b    = head.b;
            fpu_op   = head.op;
            fpu_prec = head.prec;
        end
`ifdef FPU_ISSUE_BYPASS_EN
        else if (slot_free) begin
            fpu_a    = in_entry.a;
            fpu_b    = in_entry.b;
            fpu_op   = in_entry.op;
            fpu_prec = in_entry.prec;
        end
`endif
    end

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;

        if (enq) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // a bypassed request only happens with an empty queue, so deq and bypass are exclusive
        if (deq || bypass) begin
            out_valid_d  = 1'b1;
            out_result_d = fpu_result;
            out_tag_d    = deq ? head.tag : in_tag;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign q_count    = count_q;

endmodule
